// File: rtl/mm_word_memory.sv
// ---------------------------------------------------------------------------
// mm_word_memory
//
// Word-addressed 32-bit scratchpad that serves the start/done memory
// handshake of the matrix-multiply top level. A request is accepted while
// IDLE. It waits LATENCY cycles and then completes with a one-cycle done
// pulse. Reads return operand words. Writes store result words and echo the
// written data on rdata.
//
// Parameters:
//   AW      - address width in words (depth = 2**AW)
//   LATENCY - wait cycles between acceptance and the commit edge (0..15)
//   BASE    - byte address that maps to word 0
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-low reset
//   req_start  - level request, accepted whenever high while IDLE
//   req_addr   - byte address, sampled at acceptance
//   req_we     - 1 = write, 0 = read, sampled at acceptance
//   req_wdata  - write data, sampled at acceptance
//   done       - one-cycle completion pulse
//   rdata      - read data / write echo, held until the next completion
//   err        - qualifies done: misaligned or out-of-range access
//   busy       - high in every state except IDLE
//   txn_count  - completed transactions (errored included), saturating
// ---------------------------------------------------------------------------
module mm_word_memory #(
    parameter int unsigned AW      = 6,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [15:0] txn_count
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam bit          ZERO_LAT = (LATENCY == 0);
    // The wait counter loads LATENCY-1. With zero latency WAIT is never
    // entered, so the load value is irrelevant.
    localparam logic [3:0]  CNT_LOAD = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       state_reg;
    state_t       state_next;

    logic [3:0]   cnt_reg;
    logic [31:0]  addr_reg;
    logic         we_reg;
    logic [31:0]  wdata_reg;
    logic [31:0]  rdata_reg;
    logic         err_reg;
    logic [15:0]  txn_count_reg;

    logic [31:0]  mem_reg [DEPTH];

    logic         accept;
    logic         commit;
    logic [31:0]  cur_addr;
    logic         cur_we;
    logic [31:0]  cur_wdata;
    logic [31:0]  word_off;
    logic [AW-1:0] idx;
    logic         bad_access;
    logic         wr_en;
    logic [DEPTH-1:0] wr_sel;

    // -----------------------------------------------------------------------
    // Request acceptance and commit decode
    // -----------------------------------------------------------------------
    assign accept = (state_reg == ST_IDLE) && req_start;

    // The commit edge is the edge that enters RESP. With zero latency that
    // is the acceptance edge itself.
    assign commit = (ZERO_LAT && accept) ||
                    ((state_reg == ST_WAIT) && (cnt_reg == 4'd0));

    // On a zero-latency commit the request has not been latched yet, so the
    // live inputs are used. In every other case the latched copies are used.
    assign cur_addr  = (state_reg == ST_IDLE) ? req_addr  : addr_reg;
    assign cur_we    = (state_reg == ST_IDLE) ? req_we    : we_reg;
    assign cur_wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;

    // The word offset is computed modulo 2^32. Any set bit above AW means
    // out of range. This also catches addresses below BASE, which wrap to a
    // large value.
    assign word_off   = (cur_addr - BASE) >> 2;
    assign idx        = word_off[AW-1:0];
    assign bad_access = (cur_addr[1:0] != 2'b00) || (|word_off[31:AW]);
    assign wr_en      = commit && cur_we && !bad_access;

    // Per-word write strobes.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            localparam logic [AW-1:0] WORD_IDX = AW'(gi);
            assign wr_sel[gi] = wr_en && (idx == WORD_IDX);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_start) begin
                    state_next = ZERO_LAT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        err  = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                busy = 1'b1;
            end
            ST_RESP: begin
                done = 1'b1;
                busy = 1'b1;
                err  = err_reg;
            end
            default: begin
                done = 1'b0;
                busy = 1'b0;
                err  = 1'b0;
            end
        endcase
    end

    assign rdata     = rdata_reg;
    assign txn_count = txn_count_reg;

    // -----------------------------------------------------------------------
    // Request latch, wait counter, response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg       <= 4'd0;
            addr_reg      <= 32'd0;
            we_reg        <= 1'b0;
            wdata_reg     <= 32'd0;
            rdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
            txn_count_reg <= 16'd0;
        end else begin
            if (accept) begin
                addr_reg  <= req_addr;
                we_reg    <= req_we;
                wdata_reg <= req_wdata;
                cnt_reg   <= CNT_LOAD;
            end else if ((state_reg == ST_WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (commit) begin
                if (bad_access) begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b1;
                end else if (cur_we) begin
                    rdata_reg <= cur_wdata;
                    err_reg   <= 1'b0;
                end else begin
                    // The read samples the array before this edge's write.
                    // A read commit never writes, so no hazard exists.
                    rdata_reg <= mem_reg[idx];
                    err_reg   <= 1'b0;
                end
                if (txn_count_reg != 16'hFFFF) begin
                    txn_count_reg <= txn_count_reg + 16'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage: register array so that reset can clear every word
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= cur_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_word_memory.sv
// ---------------------------------------------------------------------------
// tb_mm_word_memory
//
// Directed bench for mm_word_memory. Instance a uses LATENCY=2 and
// instance b uses LATENCY=0. Both use AW=6 and BASE=0. Inputs are driven
// and outputs are sampled on the falling edge. Latency is counted in
// falling-edge samples after the acceptance edge, so done lands on sample
// LATENCY+1.
// ---------------------------------------------------------------------------
module tb_mm_word_memory;

    logic        clk;
    logic        rst;

    logic        a_start, a_we, a_done, a_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [15:0] a_txn;

    logic        b_start, b_we, b_done, b_err, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [15:0] b_txn;

    int n_checks;
    int n_fail;

    mm_word_memory #(.AW(6), .LATENCY(2), .BASE(32'h0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_start (a_start),
        .req_addr  (a_addr),
        .req_we    (a_we),
        .req_wdata (a_wdata),
        .done      (a_done),
        .rdata     (a_rdata),
        .err       (a_err),
        .busy      (a_busy),
        .txn_count (a_txn)
    );

    mm_word_memory #(.AW(6), .LATENCY(0), .BASE(32'h0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_start (b_start),
        .req_addr  (b_addr),
        .req_we    (b_we),
        .req_wdata (b_wdata),
        .done      (b_done),
        .rdata     (b_rdata),
        .err       (b_err),
        .busy      (b_busy),
        .txn_count (b_txn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Issue one transaction on instance a (inst=0) or b (inst=1).
    // lat is the falling-edge sample on which done was seen (-1 = never).
    task automatic do_txn(input bit inst, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic e);
        @(negedge clk);
        if (!inst) begin a_start = 1'b1; a_addr = addr; a_we = we; a_wdata = wd; end
        else       begin b_start = 1'b1; b_addr = addr; b_we = we; b_wdata = wd; end
        lat = -1; rd = 32'hx; e = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            b_start = 1'b0;
            if ((!inst && a_done) || (inst && b_done)) begin
                lat = c;
                rd  = inst ? b_rdata : a_rdata;
                e   = inst ? b_err   : a_err;
                break;
            end
        end
        $display("txn inst=%0d addr=%08h we=%0d wdata=%08h -> lat=%0d rdata=%08h err=%0d",
                 inst, addr, we, wd, lat, rd, e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_start = 0; a_addr = 0; a_we = 0; a_wdata = 0;
        b_start = 0; b_addr = 0; b_we = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", a_done); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", a_err); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        n_checks++; if (a_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %08h exp 0", a_rdata); end
        n_checks++; if (a_txn !== 16'd0) begin n_fail++; $display("FAIL reset_txn got %0d exp 0", a_txn); end
        n_checks++; if (b_txn !== 16'd0) begin n_fail++; $display("FAIL reset_txn_b got %0d exp 0", b_txn); end
        rst = 1'b1;
    endtask

    task automatic test_read_base();
        int lat; logic [31:0] rd; logic e;
        do_txn(0, 32'h0, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL base_latency got %0d exp 3", lat); end
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL base_rdata got %08h exp 0", rd); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL base_err got %b exp 0", e); end
        n_checks++; if (a_txn !== 16'd1) begin n_fail++; $display("FAIL base_txn got %0d exp 1", a_txn); end
    endtask

    // Write then read 0x10 with req_start held high; the address/we change
    // right after the first done is seen.
    task automatic test_back_to_back();
        int d1, d2; logic [31:0] r1, r2; logic e2, b_idle, b_next;
        d1 = -1; d2 = -1; r1 = 0; r2 = 0; e2 = 1'bx; b_idle = 1'bx; b_next = 1'bx;
        @(negedge clk);
        a_start = 1'b1; a_addr = 32'h10; a_we = 1'b1; a_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 30 && d2 < 0; c++) begin
            @(negedge clk);
            if (d1 > 0 && c == d1 + 1) b_idle = a_busy;
            if (d1 > 0 && c == d1 + 2) b_next = a_busy;
            if (a_done) begin
                if (d1 < 0) begin
                    d1 = c; r1 = a_rdata;
                    a_addr = 32'h10; a_we = 1'b0; a_wdata = 32'h0;
                end else begin
                    d2 = c; r2 = a_rdata; e2 = a_err; a_start = 1'b0;
                end
            end
        end
        a_start = 1'b0;
        $display("txn b2b write 00000010 DEADBEEF then read: done@%0d,%0d rdata=%08h,%08h", d1, d2, r1, r2);
        n_checks++; if (d1 !== 3) begin n_fail++; $display("FAIL b2b_first_latency got %0d exp 3", d1); end
        n_checks++; if (r1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_write_echo got %08h exp deadbeef", r1); end
        n_checks++; if (b_idle !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap_busy got %b exp 0", b_idle); end
        n_checks++; if (b_next !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept_busy got %b exp 1", b_next); end
        n_checks++; if (d2 - d1 !== 4 || d2 < 0) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 4", d2 - d1); end
        n_checks++; if (r2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_read_data got %08h exp deadbeef", r2); end
        n_checks++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL b2b_read_err got %b exp 0", e2); end
        n_checks++; if (a_txn !== 16'd3) begin n_fail++; $display("FAIL b2b_txn got %0d exp 3", a_txn); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e;
        do_txn(0, 32'h102, 1'b1, 32'h5555_AAAA, lat, rd, e);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL misalign_latency got %0d exp 3", lat); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b exp 1", e); end
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL misalign_rdata got %08h exp 0", rd); end
        @(negedge clk);
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_low_in_idle got %b exp 0", a_err); end
        do_txn(0, 32'h100, 1'b1, 32'h1111_2222, lat, rd, e);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL range_err got %b exp 1", e); end
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL range_rdata got %08h exp 0", rd); end
        do_txn(0, 32'h0FC, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL top_word_untouched got %08h exp 0", rd); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL top_word_err got %b exp 0", e); end
        do_txn(0, 32'h0FC, 1'b1, 32'hA5A5_0001, lat, rd, e);
        do_txn(0, 32'h0FC, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL top_word_rw got %08h exp a5a50001", rd); end
        @(negedge clk);
        n_checks++; if (a_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rdata_hold got %08h exp a5a50001", a_rdata); end
        n_checks++; if (a_txn !== 16'd8) begin n_fail++; $display("FAIL err_txn got %0d exp 8", a_txn); end
    endtask

    task automatic test_zero_latency();
        int lat; logic [31:0] rd; logic e;
        do_txn(1, 32'h4, 1'b1, 32'd5, lat, rd, e);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL l0_write_latency got %0d exp 1", lat); end
        n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL l0_write_echo got %08h exp 5", rd); end
        do_txn(1, 32'h4, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL l0_read_latency got %0d exp 1", lat); end
        n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL l0_read_data got %08h exp 5", rd); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL l0_read_err got %b exp 0", e); end
        n_checks++; if (b_txn !== 16'd2) begin n_fail++; $display("FAIL l0_txn got %0d exp 2", b_txn); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic e; int seen_done;
        @(negedge clk);
        a_start = 1'b1; a_addr = 32'h8; a_we = 1'b1; a_wdata = 32'h1234;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait got %b exp 1", a_busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", a_busy); end
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (a_done) seen_done++;
            @(negedge clk);
        end
        $display("txn inst=0 addr=00000008 we=1 wdata=00001234 -> abandoned by reset, done pulses=%0d", seen_done);
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d exp 0", seen_done); end
        do_txn(0, 32'h8, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL midrst_read got %08h exp 0", rd); end
        do_txn(0, 32'h10, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL midrst_mem_cleared got %08h exp 0", rd); end
        n_checks++; if (a_txn !== 16'd2) begin n_fail++; $display("FAIL midrst_txn got %0d exp 2", a_txn); end
    endtask

    task automatic test_saturation();
        int lat; logic [31:0] rd; logic e;
        @(negedge clk);
        force dut_b.txn_count_reg = 16'hFFFE;
        #1;
        release dut_b.txn_count_reg;
        do_txn(1, 32'h4, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (b_txn !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %04h exp ffff", b_txn); end
        do_txn(1, 32'h102, 1'b0, 32'h0, lat, rd, e);
        n_checks++; if (b_txn !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %04h exp ffff", b_txn); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL sat_err got %b exp 1", e); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read_base();
        test_back_to_back();
        test_errors();
        test_zero_latency();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
